pipe_front_regs: RTL and testbench

- Front-end pipeline state of the 5-stage MIPS core: PC register, IF/ID register and ID/EX register.
- It is the consumer of the hazard unit's stallPC/stallID/flushEX outputs and applies them cycle by cycle.
- It also takes the next-PC redirect from the D-stage branch/jump logic (delay-slot architecture).
- It keeps a stall-cycle counter for debug.

---
 rtl/pipe_front_regs.sv | 91 +++++++++
 tb/tb_pipe_front_regs.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the 5-stage MIPS core: PC, IF/ID and ID/EX registers.
// The hazard unit's stall/flush controls and the D-stage next-PC redirect are applied cycle by cycle.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallPC,
  input  logic             stallID,
  input  logic             flushEX,
  input  logic             npcSel,
  input  logic [31:0]      npc,
  input  logic [31:0]      instr_F,
  input  logic [31:0]      rsVal_D,
  input  logic [31:0]      rtVal_D,
  input  logic [31:0]      imm32_D,
  output logic [31:0]      pc_F,
  output logic [31:0]      instr_D,
  output logic [31:0]      pc_D,
  output logic             valid_D,
  output logic [31:0]      instr_E,
  output logic [31:0]      pc_E,
  output logic [31:0]      rsVal_E,
  output logic [31:0]      rtVal_E,
  output logic [31:0]      imm32_E,
  output logic             valid_E,
  output logic [CNT_W-1:0] stallCnt
);

  logic [31:0] pcNext;

  // A stalled PC ignores the redirect; the branch stays in D and resolves again.
  always_comb begin
    pcNext = pc_F + 32'd4;
    if (stallPC)     pcNext = pc_F;
    else if (npcSel) pcNext = npc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_F <= RESET_PC;
    else        pc_F <= pcNext;
  end

  // IF/ID has no flush: the instruction behind a branch is its delay slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_D <= NOP_INSTR;
      pc_D    <= 32'd0;
      valid_D <= 1'b0;
    end else if (!stallID) begin
      instr_D <= instr_F;
      pc_D    <= pc_F;
      valid_D <= 1'b1;
    end
  end

  // ID/EX never holds; a bubble still records pc_D for exception reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_E <= NOP_INSTR;
      pc_E    <= 32'd0;
      rsVal_E <= 32'd0;
      rtVal_E <= 32'd0;
      imm32_E <= 32'd0;
      valid_E <= 1'b0;
    end else if (flushEX) begin
      instr_E <= NOP_INSTR;
      pc_E    <= pc_D;
      rsVal_E <= 32'd0;
      rtVal_E <= 32'd0;
      imm32_E <= 32'd0;
      valid_E <= 1'b0;
    end else begin
      instr_E <= instr_D;
      pc_E    <= pc_D;
      rsVal_E <= rsVal_D;
      rtVal_E <= rtVal_D;
      imm32_E <= imm32_D;
      valid_E <= valid_D;
    end
  end

  // Debug count of bubble cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        stallCnt <= '0;
    else if (flushEX && !(&stallCnt))  stallCnt <= stallCnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed scenarios then random control/data traffic,
// compared every cycle against a cycle-level reference model of the three registers.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallPC, stallID, flushEX, npcSel;
  logic [31:0] npc, instr_F, rsVal_D, rtVal_D, imm32_D;

  logic [31:0] pc_F, instr_D, pc_D, instr_E, pc_E, rsVal_E, rtVal_E, imm32_E;
  logic        valid_D, valid_E;
  logic [31:0] stallCnt;

  logic [31:0] pc_F4, instr_D4, pc_D4, instr_E4, pc_E4, rsVal_E4, rtVal_E4, imm32_E4;
  logic        valid_D4, valid_E4;
  logic [3:0]  stallCnt4;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state
  logic [31:0] m_pc, m_instr_d, m_pc_d, m_instr_e, m_pc_e, m_rs_e, m_rt_e, m_imm_e;
  logic        m_valid_d, m_valid_e;
  longint      m_cnt, m_cnt4;

  pipe_front_regs dut (
    .clk(clk), .reset(reset), .stallPC(stallPC), .stallID(stallID), .flushEX(flushEX),
    .npcSel(npcSel), .npc(npc), .instr_F(instr_F), .rsVal_D(rsVal_D), .rtVal_D(rtVal_D),
    .imm32_D(imm32_D), .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .instr_E(instr_E), .pc_E(pc_E), .rsVal_E(rsVal_E), .rtVal_E(rtVal_E), .imm32_E(imm32_E),
    .valid_E(valid_E), .stallCnt(stallCnt)
  );

  pipe_front_regs #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stallPC(stallPC), .stallID(stallID), .flushEX(flushEX),
    .npcSel(npcSel), .npc(npc), .instr_F(instr_F), .rsVal_D(rsVal_D), .rtVal_D(rtVal_D),
    .imm32_D(imm32_D), .pc_F(pc_F4), .instr_D(instr_D4), .pc_D(pc_D4), .valid_D(valid_D4),
    .instr_E(instr_E4), .pc_E(pc_E4), .rsVal_E(rsVal_E4), .rtVal_E(rtVal_E4), .imm32_E(imm32_E4),
    .valid_E(valid_E4), .stallCnt(stallCnt4)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_instr_d = 32'h0; m_pc_d = 32'h0; m_valid_d = 1'b0;
    m_instr_e = 32'h0; m_pc_e = 32'h0; m_rs_e = 32'h0; m_rt_e = 32'h0; m_imm_e = 32'h0;
    m_valid_e = 1'b0; m_cnt = 0; m_cnt4 = 0;
  endtask

  // one clock edge of the front end, computed from the stage rules in dependency order
  task automatic model_edge();
    if (flushEX) begin
      m_instr_e = 32'h0; m_valid_e = 1'b0; m_rs_e = 0; m_rt_e = 0; m_imm_e = 0;
      m_pc_e = m_pc_d;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end else begin
      m_instr_e = m_instr_d; m_pc_e = m_pc_d; m_valid_e = m_valid_d;
      m_rs_e = rsVal_D; m_rt_e = rtVal_D; m_imm_e = imm32_D;
    end
    if (!stallID) begin
      m_instr_d = instr_F; m_pc_d = m_pc; m_valid_d = 1'b1;
    end
    if (!stallPC) m_pc = npcSel ? npc : m_pc + 32'd4;
  endtask

  task automatic check_all();
    check_val("pc_F", pc_F, m_pc);
    check_val("instr_D", instr_D, m_instr_d);
    check_val("pc_D", pc_D, m_pc_d);
    check_val("valid_D", {31'd0, valid_D}, {31'd0, m_valid_d});
    check_val("instr_E", instr_E, m_instr_e);
    check_val("pc_E", pc_E, m_pc_e);
    check_val("rsVal_E", rsVal_E, m_rs_e);
    check_val("rtVal_E", rtVal_E, m_rt_e);
    check_val("imm32_E", imm32_E, m_imm_e);
    check_val("valid_E", {31'd0, valid_E}, {31'd0, m_valid_e});
    check_val("stallCnt", stallCnt, 32'(m_cnt));
    check_val("stallCnt4", {28'd0, stallCnt4}, 32'(m_cnt4));
    check_val("pc_F4", pc_F4, m_pc);
  endtask

  // driver: inputs are set #1 after an edge, sampled #1 after the next edge
  task automatic apply(input logic sp, input logic sd, input logic fe, input logic sel,
                       input logic [31:0] target, input logic [31:0] ins);
    stallPC = sp; stallID = sd; flushEX = fe; npcSel = sel; npc = target; instr_F = ins;
    rsVal_D = $urandom; rtVal_D = $urandom; imm32_D = $urandom;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // asynchronous reset pulse placed between edges
  task automatic async_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {stallPC, stallID, flushEX, npcSel} = 4'b0;
    npc = 0; instr_F = 0; rsVal_D = 0; rtVal_D = 0; imm32_D = 0;
    model_reset();
    #13;
    check_all();
    reset = 1'b1;

    // straight-line fetch
    apply(0, 0, 0, 0, 0, 32'h2401_0001);
    check_val("tp1_pc_e1", pc_F, 32'h3004);
    check_val("tp1_instr_D", instr_D, 32'h2401_0001);
    apply(0, 0, 0, 0, 0, 32'h2401_0001);
    check_val("tp1_pc_E", pc_E, 32'h3000);
    check_val("tp1_valid_E", {31'd0, valid_E}, 32'd1);
    apply(0, 0, 0, 0, 0, 32'h2401_0002);
    check_val("tp2_pc_D", pc_D, 32'h3008);

    // load-use stall, then branch redirect with delay slot
    apply(1, 1, 1, 0, 0, 32'hDEAD_BEEF);
    check_val("tp2_pc_hold", pc_F, 32'h300C);
    check_val("tp2_pc_E", pc_E, 32'h3008);
    check_val("tp2_cnt", stallCnt, 32'd1);
    apply(0, 0, 0, 1, 32'h3040, 32'h0000_0011);
    check_val("tp3_pc", pc_F, 32'h3040);
    check_val("tp3_slot_pc_D", pc_D, 32'h300C);
    check_val("tp3_valid_E", {31'd0, valid_E}, 32'd1);

    // redirect while stalled is ignored until the stall clears
    apply(1, 1, 1, 1, 32'h3100, 32'h0000_0022);
    check_val("tp4_hold", pc_F, 32'h3040);
    apply(0, 0, 0, 1, 32'h3100, 32'h0000_0033);
    check_val("tp4_redirect", pc_F, 32'h3100);

    // PC wrap and counter saturation
    apply(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h1);
    apply(0, 0, 0, 0, 0, 32'h2);
    check_val("tp5_wrap", pc_F, 32'h0);
    for (int i = 0; i < 20; i++) apply(1, 1, 1, 0, 0, 32'h3);
    check_val("tp5_sat4", {28'd0, stallCnt4}, 32'hF);

    // asynchronous reset mid-stall, fetch resumes at RESET_PC
    stallPC = 1; stallID = 1; flushEX = 1;
    async_reset();
    apply(0, 0, 0, 0, 0, 32'h4);
    check_val("tp6_resume", pc_F, 32'h3004);

    // random traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC, $urandom);
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
